ram_arbiter_2p: RTL and testbench



---
 rtl/ram_arbiter_2p.sv | 95 +++++++++
 tb/tb_ram_arbiter_2p.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_2p.sv
// Two-requester arbiter in front of a single-port async-read RAM.
// Build option: define RAM_ARB_RR_EN for round-robin, else A has fixed priority.
module ram_arbiter_2p #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  logic fav_b;
  logic gnt_a;
  logic gnt_b;

`ifdef RAM_ARB_RR_EN
  logic prio;

  assign fav_b = prio;

  // Loser of a contended cycle is favoured next time.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (a_valid && b_valid) begin
      prio <= ~gnt_b;
    end
  end
`else
  assign fav_b = 1'b0;
`endif

  assign gnt_a = !rst && a_valid
               && (!b_valid || !fav_b);
  assign gnt_b = !rst && b_valid
               && (!a_valid || fav_b);

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_in   = '0;
    unique case (1'b1)
      gnt_a: begin
        ram_we   = a_we;
        ram_addr = a_addr;
        ram_in   = a_wdata;
      end
      gnt_b: begin
        ram_we   = b_we;
        ram_addr = b_addr;
        ram_in   = b_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= gnt_a;
      b_rvalid <= gnt_b;
      if (gnt_a) begin
        a_rdata <= a_we ? '0 : ram_out;
      end
      if (gnt_b) begin
        b_rdata <= b_we ? '0 : ram_out;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Vector-table bench for ram_arbiter_2p with a behavioural RAM.
// Expected values follow the build selected by RAM_ARB_RR_EN.
module tb_ram_arbiter_2p;

`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       a_valid, a_we, a_ready, a_rvalid;
  logic [3:0] a_addr;
  logic [7:0] a_wdata, a_rdata;
  logic       b_valid, b_we, b_ready, b_rvalid;
  logic [3:0] b_addr;
  logic [7:0] b_wdata, b_rdata;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_in, ram_out;
  logic [7:0] mem [16];

  int checks;
  int failures;

  ram_arbiter_2p #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_we(a_we),
    .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rvalid(a_rvalid),
    .a_rdata(a_rdata),
    .b_valid(b_valid), .b_we(b_we),
    .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rvalid(b_rvalid),
    .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_in(ram_in), .ram_out(ram_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_in;
  end
  assign ram_out = mem[ram_addr];

  typedef struct {
    logic       rst;
    logic       av, awe;
    logic [3:0] aad;
    logic [7:0] awd;
    logic       bv, bwe;
    logic [3:0] bad;
    logic [7:0] bwd;
    logic       ar, br, we;
    logic [3:0] ad;
    logic [7:0] din;
    logic       arv;
    logic [7:0] ard;
    logic       brv;
    logic [7:0] brd;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(
    input logic r,
    input logic av, input logic awe,
    input logic [3:0] aad, input logic [7:0] awd,
    input logic bv, input logic bwe,
    input logic [3:0] bad, input logic [7:0] bwd,
    input logic ar, input logic br, input logic we,
    input logic [3:0] ad, input logic [7:0] din,
    input logic arv, input logic [7:0] ard,
    input logic brv, input logic [7:0] brd);
    vec_t v;
    v.rst = r;
    v.av = av; v.awe = awe; v.aad = aad; v.awd = awd;
    v.bv = bv; v.bwe = bwe; v.bad = bad; v.bwd = bwd;
    v.ar = ar; v.br = br; v.we = we; v.ad = ad;
    v.din = din; v.arv = arv; v.ard = ard;
    v.brv = brv; v.brd = brd;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h want=%0h",
               name, idx, act, exp);
    end
  endtask

  initial begin
    logic [7:0] bh;
    int cnt;
    checks = 0;
    failures = 0;
    bh = RR ? 8'h00 : 8'hEA;
    //             rst av we aad awd   bv we bad bwd    ar br we ad din    arv ard    brv brd
    tbl[0]  = mk(1, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,0,0,8'h00, 0,8'h00, 0,8'h00);
    tbl[1]  = mk(0, 0,0,0,8'h00, 1,1,2,8'hFF, 0,1,1,2,8'hFF, 0,8'h00, 1,8'h00);
    tbl[2]  = mk(0, 0,0,0,8'h00, 1,1,3,8'h00, 0,1,1,3,8'h00, 0,8'h00, 1,8'h00);
    tbl[3]  = mk(0, 0,0,0,8'h00, 1,1,15,8'h11, 0,1,1,15,8'h11, 0,8'h00, 1,8'h00);
    tbl[4]  = mk(0, 1,1,0,8'h81, 0,0,0,8'h00, 1,0,1,0,8'h81, 1,8'h00, 0,8'h00);
    tbl[5]  = mk(0, 1,0,0,8'h00, 0,0,0,8'h00, 1,0,0,0,8'h00, 1,8'h81, 0,8'h00);
    tbl[6]  = mk(0, 1,1,1,8'hEA, 0,0,0,8'h00, 1,0,1,1,8'hEA, 1,8'h00, 0,8'h00);
    tbl[7]  = mk(0, 0,0,0,8'h00, 1,0,1,8'h00, 0,1,0,1,8'h00, 0,8'h00, 1,8'hEA);
    tbl[8]  = mk(0, 1,0,2,8'h00, 1,0,3,8'h00, 1,0,0,2,8'h00, 1,8'hFF, 0,8'hEA);
    tbl[9]  = mk(0, 1,0,2,8'h00, 1,0,3,8'h00, !RR,RR,0,RR?4'd3:4'd2,8'h00, !RR,8'hFF, RR,bh);
    tbl[10] = mk(0, 1,0,2,8'h00, 1,0,3,8'h00, 1,0,0,2,8'h00, 1,8'hFF, 0,bh);
    tbl[11] = mk(0, 1,0,2,8'h00, 1,0,3,8'h00, !RR,RR,0,RR?4'd3:4'd2,8'h00, !RR,8'hFF, RR,bh);
    tbl[12] = mk(0, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,0,0,8'h00, 0,8'hFF, 0,bh);
    tbl[13] = mk(0, 0,1,5,8'h77, 0,1,6,8'h66, 0,0,0,0,8'h00, 0,8'hFF, 0,bh);
    tbl[14] = mk(0, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,0,0,8'h00, 0,8'hFF, 0,bh);
    tbl[15] = mk(0, 0,0,0,8'h00, 1,0,15,8'h00, 0,1,0,15,8'h00, 0,8'hFF, 1,8'h11);
    tbl[16] = mk(0, 1,0,2,8'h00, 1,0,3,8'h00, 1,0,0,2,8'h00, 1,8'hFF, 0,8'h11);
    tbl[17] = mk(1, 1,0,0,8'h00, 1,1,15,8'h5A, 0,0,0,0,8'h00, 0,8'h00, 0,8'h00);
    tbl[18] = mk(0, 1,0,0,8'h00, 1,0,3,8'h00, 1,0,0,0,8'h00, 1,8'h81, 0,8'h00);
    tbl[19] = mk(0, 0,0,0,8'h00, 1,0,15,8'h00, 0,1,0,15,8'h00, 0,8'h81, 1,8'h11);

    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].rst;
      a_valid = tbl[i].av; a_we = tbl[i].awe;
      a_addr = tbl[i].aad; a_wdata = tbl[i].awd;
      b_valid = tbl[i].bv; b_we = tbl[i].bwe;
      b_addr = tbl[i].bad; b_wdata = tbl[i].bwd;
      #2;
      check("a_ready", i, 32'(a_ready), 32'(tbl[i].ar));
      check("b_ready", i, 32'(b_ready), 32'(tbl[i].br));
      check("ram_we", i, 32'(ram_we), 32'(tbl[i].we));
      check("ram_addr", i, 32'(ram_addr), 32'(tbl[i].ad));
      check("ram_in", i, 32'(ram_in), 32'(tbl[i].din));
      @(posedge clk);
      #1;
      check("a_rvalid", i, 32'(a_rvalid), 32'(tbl[i].arv));
      check("a_rdata", i, 32'(a_rdata), 32'(tbl[i].ard));
      check("b_rvalid", i, 32'(b_rvalid), 32'(tbl[i].brv));
      check("b_rdata", i, 32'(b_rdata), 32'(tbl[i].brd));
    end

    // Sustained contention: B shares the RAM only in the round-robin build.
    cnt = 0;
    rst = 1'b0;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd0; a_wdata = 8'h00;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 4'd1; b_wdata = 8'h00;
    for (int k = 0; k < 4; k++) begin
      #2;
      check("one_grant", k, 32'(a_ready ^ b_ready), 32'd1);
      if (b_ready) cnt++;
      @(posedge clk);
      #1;
    end
    check("b_share", 0, 32'(cnt), RR ? 32'd2 : 32'd0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    #2;
    check("idle_we", 0, 32'(ram_we), 32'd0);
    @(posedge clk);
    #1;
    check("idle_arv", 0, 32'(a_rvalid), 32'd0);
    check("idle_brv", 0, 32'(b_rvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
